// File: rtl/lcd_bus_responder_if.sv
// LCD parallel bus between an HD44780-style controller (master) and the LCD (slave).
interface lcd_bus_responder_if;
  logic       LCD_EN;
  logic       LCD_RW;
  logic       LCD_RS;
  logic [7:0] LCD_DATA_IN;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (
    output LCD_EN, LCD_RW, LCD_RS, LCD_DATA_IN,
    input  lcd_data_out, lcd_data_oe
  );

  modport slave (
    input  LCD_EN, LCD_RW, LCD_RS, LCD_DATA_IN,
    output lcd_data_out, lcd_data_oe
  );
endinterface

// File: rtl/lcd_bus_responder.sv
// Cycle-accurate HD44780-style LCD responder: decodes bus writes, holds a 2x16
// character buffer, answers status/data reads and models busy timing.
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 76500
) (
  input  logic                clk,
  input  logic                rst,
  lcd_bus_responder_if.slave  bus,
  input  logic [4:0]          rd_addr,
  output logic [7:0]          rd_char,
  output logic                busy,
  output logic [6:0]          addr_counter,
  output logic                display_on,
  output logic [1:0]          func_8bit_2line,
  output logic                violation
);

  localparam logic [16:0] BUSY_T  = 17'(BUSY_CYCLES);
  localparam logic [16:0] CLEAR_T = 17'(CLEAR_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EXEC} state_t;

  state_t      state;
  logic [16:0] timer;
  logic [4:0]  fill_idx;
  logic        from_rst;
  logic [6:0]  ac;
  logic        id;
  logic [7:0]  mem [32];

  logic       en_q, rw_q, rs_q;
  logic [7:0] data_q;
  logic       wr_strobe, rd_fall, rd_active;
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] ac_byte;

  // Only the visible 2x16 window is stored: 0x00-0x0F and 0x40-0x4F share ac[5:4]==0.
  function automatic logic ac_mapped(input logic [6:0] a);
    return (a[5:4] == 2'b00);
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else if ((a < 7'h27) || ((a >= 7'h40) && (a < 7'h67))) return a + 7'd1;
      else                 return 7'h00;
    end else begin
      if (a == 7'h40)      return 7'h27;
      else if (a == 7'h00) return 7'h67;
      else                 return a - 7'd1;
    end
  endfunction

  assign wr_strobe = en_q & ~bus.LCD_EN & ~rw_q;
  assign rd_fall   = en_q & ~bus.LCD_EN & rw_q & rs_q;
  assign rd_active = bus.LCD_EN & bus.LCD_RW;
  assign ac_byte   = ac_mapped(ac) ? mem[{ac[6], ac[3:0]}] : 8'h20;
  assign addr_counter = ac;

  // Bus sample stage
  always_ff @(posedge clk) begin
    data_q <= bus.LCD_DATA_IN;
    if (rst) begin
      en_q <= 1'b0;
      rw_q <= 1'b0;
      rs_q <= 1'b0;
    end else begin
      en_q <= bus.LCD_EN;
      rw_q <= bus.LCD_RW;
      rs_q <= bus.LCD_RS;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = fill_idx;
    mem_wdata = 8'h20;
    if (state == S_FILL) begin
      mem_we = 1'b1;
    end else if ((state == S_IDLE) && wr_strobe && rs_q && ac_mapped(ac)) begin
      mem_we    = 1'b1;
      mem_waddr = {ac[6], ac[3:0]};
      mem_wdata = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Command execute / busy stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_FILL;
      busy            <= 1'b1;
      fill_idx        <= 5'd0;
      from_rst        <= 1'b1;
      timer           <= 17'd0;
      ac              <= 7'h00;
      id              <= 1'b1;
      display_on      <= 1'b0;
      func_8bit_2line <= 2'b00;
      violation       <= 1'b0;
    end else begin
      if (rd_fall) ac <= ac_step(ac, id);
      if (wr_strobe && busy) violation <= 1'b1;
      case (state)
        S_IDLE: begin
          if (wr_strobe) begin
            busy  <= 1'b1;
            state <= S_EXEC;
            timer <= BUSY_T;
            if (rs_q) begin
              ac <= ac_step(ac, id);
            end else begin
              casez (data_q)
                8'b1???????: ac <= data_q[6:0];
                8'b001?????: func_8bit_2line <= data_q[4:3];
                8'b00001???: display_on <= data_q[2];
                8'b000001??: id <= data_q[1];
                8'b0000001?: begin
                  ac    <= 7'h00;
                  timer <= CLEAR_T;
                end
                8'b00000001: begin
                  state    <= S_FILL;
                  fill_idx <= 5'd0;
                  from_rst <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        S_FILL: begin
          fill_idx <= fill_idx + 5'd1;
          if (fill_idx == 5'd31) begin
            ac <= 7'h00;
            id <= 1'b1;
            // The power-on fill skips the long clear wait.
            if (from_rst) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_EXEC;
              timer <= CLEAR_T;
            end
          end
        end
        S_EXEC: begin
          if (timer <= 17'd1) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 17'd1;
          end
        end
        default: begin
          state    <= S_FILL;
          busy     <= 1'b1;
          fill_idx <= 5'd0;
        end
      endcase
    end
  end

  // Read-back output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.lcd_data_out <= 8'h00;
      bus.lcd_data_oe  <= 1'b0;
      rd_char          <= 8'h00;
    end else begin
      bus.lcd_data_oe <= rd_active;
      if (!rd_active)      bus.lcd_data_out <= 8'h00;
      else if (bus.LCD_RS) bus.lcd_data_out <= ac_byte;
      else                 bus.lcd_data_out <= {busy, ac};
      rd_char <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomized bench for lcd_bus_responder against a behavioural LCD model.
module tb_lcd_bus_responder;
  localparam int BUSY_CYCLES  = 40;
  localparam int CLEAR_CYCLES = 150;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic       busy;
  logic [6:0] addr_counter;
  logic       display_on;
  logic [1:0] func_8bit_2line;
  logic       violation;

  lcd_bus_responder_if bus ();

  lcd_bus_responder #(.BUSY_CYCLES(BUSY_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rd_addr(rd_addr), .rd_char(rd_char),
    .busy(busy), .addr_counter(addr_counter), .display_on(display_on),
    .func_8bit_2line(func_8bit_2line), .violation(violation)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_buf [32];
  logic [6:0] m_ac;
  bit         m_id;
  bit         m_disp;
  logic [1:0] m_func;
  bit         m_viol;
  int         m_busy_end;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DDRAM as an 80-entry ring: 0x00-0x27 then 0x40-0x67.
  function automatic logic [6:0] m_step(input logic [6:0] a, input bit inc);
    int p;
    bit valid;
    valid = (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    if (!valid) return inc ? 7'h00 : a - 7'd1;
    p = (a >= 7'h40) ? int'(a) - 64 + 40 : int'(a);
    p = inc ? (p + 1) % 80 : (p + 79) % 80;
    return (p >= 40) ? 7'(p - 40 + 64) : 7'(p);
  endfunction

  function automatic bit m_mapped(input logic [6:0] a);
    return (a <= 7'h0F) || ((a >= 7'h40) && (a <= 7'h4F));
  endfunction

  function automatic int m_idx(input logic [6:0] a);
    return (a >= 7'h40) ? int'(a) - 64 + 16 : int'(a);
  endfunction

  function automatic logic [7:0] m_rd_byte();
    return m_mapped(m_ac) ? m_buf[m_idx(m_ac)] : 8'h20;
  endfunction

  task automatic m_apply(input bit rs, input logic [7:0] d, input int s);
    int n;
    n = BUSY_CYCLES;
    if (s - 1 < m_busy_end) begin
      m_viol = 1;
      return;
    end
    if (rs) begin
      if (m_mapped(m_ac)) m_buf[m_idx(m_ac)] = d;
      m_ac = m_step(m_ac, m_id);
    end
    else if (d[7]) m_ac = d[6:0];
    else if (d[6]) begin end
    else if (d[5]) m_func = d[4:3];
    else if (d[4]) begin end
    else if (d[3]) m_disp = d[2];
    else if (d[2]) m_id = d[1];
    else if (d[1]) begin m_ac = 7'h00; n = CLEAR_CYCLES; end
    else if (d[0]) begin
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
      m_ac = 7'h00;
      m_id = 1;
      n = 32 + CLEAR_CYCLES;
    end
    m_busy_end = s + n;
  endtask

  task automatic bus_write(input bit rs, input logic [7:0] d);
    tick();
    bus.LCD_EN = 1'b1; bus.LCD_RW = 1'b0; bus.LCD_RS = rs; bus.LCD_DATA_IN = d;
    tick();
    bus.LCD_EN = 1'b0;
    tick();
    m_apply(rs, d, cyc);
  endtask

  task automatic bus_read(input bit rs);
    logic [7:0] exp;
    tick();
    bus.LCD_EN = 1'b1; bus.LCD_RW = 1'b1; bus.LCD_RS = rs;
    tick();
    if (rs) exp = m_rd_byte();
    else    exp = {((cyc - 1) < m_busy_end), m_ac};
    chk("rd_oe_on", 32'(bus.lcd_data_oe), 32'd1);
    chk(rs ? "rd_data" : "rd_status", 32'(bus.lcd_data_out), 32'(exp));
    bus.LCD_EN = 1'b0;
    tick();
    chk("rd_oe_off", 32'(bus.lcd_data_oe), 32'd0);
    chk("rd_out_idle", 32'(bus.lcd_data_out), 32'd0);
    if (rs) m_ac = m_step(m_ac, m_id);
  endtask

  task automatic wait_idle();
    while (cyc < m_busy_end - 1) tick();
    if (cyc == m_busy_end - 1) chk("busy_last", 32'(busy), 32'd1);
    while (cyc < m_busy_end) tick();
    chk("busy_drop", 32'(busy), 32'd0);
  endtask

  task automatic check_state();
    chk("ac", 32'(addr_counter), 32'(m_ac));
    chk("display_on", 32'(display_on), 32'(m_disp));
    chk("func", 32'(func_8bit_2line), 32'(m_func));
    chk("violation", 32'(violation), 32'(m_viol));
  endtask

  task automatic check_rd(input logic [4:0] a);
    rd_addr = a;
    tick();
    chk("rd_char", 32'(rd_char), 32'(m_buf[a]));
  endtask

  task automatic check_all_buf();
    for (int i = 0; i < 32; i++) check_rd(5'(i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out", 32'(bus.lcd_data_out), 32'd0);
    chk("rst_oe", 32'(bus.lcd_data_oe), 32'd0);
    chk("rst_rd_char", 32'(rd_char), 32'd0);
    chk("rst_ac", 32'(addr_counter), 32'd0);
    chk("rst_disp", 32'(display_on), 32'd0);
    chk("rst_func", 32'(func_8bit_2line), 32'd0);
    chk("rst_viol", 32'(violation), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    m_busy_end = cyc + 32;
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_ac = 7'h00; m_id = 1; m_disp = 0; m_func = 2'b00; m_viol = 0;
  endtask

  function automatic logic [6:0] rand_ac();
    case ($urandom_range(0, 3))
      0:       return 7'($urandom_range(0, 15));
      1:       return 7'($urandom_range(64, 79));
      2:       return ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 39)) : 7'($urandom_range(64, 103));
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int op;
    rst = 1'b1;
    rd_addr = 5'd0;
    bus.LCD_EN = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_DATA_IN = 8'h00;

    do_reset();
    wait_idle();
    check_rd(5'h00);
    check_rd(5'h1F);

    bus_write(0, 8'h38); wait_idle();
    bus_write(0, 8'h08); wait_idle();
    bus_write(0, 8'h01);
    cnt = 0;
    while (busy && cnt < 1000) begin tick(); cnt++; end
    chk("clear_busy_len", 32'(cnt), 32'(32 + CLEAR_CYCLES));
    wait_idle();
    bus_write(0, 8'h06); wait_idle();
    bus_write(0, 8'h0C); wait_idle();
    check_state();
    chk("init_func", 32'(func_8bit_2line), 32'd3);
    chk("init_disp", 32'(display_on), 32'd1);

    bus_write(0, 8'hCF); wait_idle();
    bus_write(1, 8'h7A); wait_idle();
    check_rd(5'h1F);
    chk("ac_0x50", 32'(addr_counter), 32'h50);

    bus_write(0, 8'h04); wait_idle();
    bus_write(0, 8'h80); wait_idle();
    bus_write(1, 8'h31); wait_idle();
    chk("ac_wrap_dn", 32'(addr_counter), 32'h67);
    bus_write(1, 8'h32); wait_idle();
    chk("ac_0x66", 32'(addr_counter), 32'h66);
    check_all_buf();

    bus_write(0, 8'h06); wait_idle();
    bus_write(0, 8'h85); wait_idle();
    bus_write(1, 8'h55);
    bus_read(0);
    bus_write(1, 8'h66);
    wait_idle();
    check_state();
    chk("viol_set", 32'(violation), 32'd1);
    check_rd(5'h05);
    check_rd(5'h06);

    bus_write(0, 8'hA7); wait_idle();
    bus_write(1, 8'h41); wait_idle();
    chk("ac_wrap_up", 32'(addr_counter), 32'h40);
    bus_write(0, 8'h80);
    repeat (5) tick();
    do_reset();
    wait_idle();
    check_all_buf();
    check_state();

    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 11));
      case (op)
        0:    bus_write(0, {1'b1, rand_ac()});
        1, 2: bus_write(1, 8'($urandom));
        3:    bus_write(0, 8'h04 | 8'($urandom_range(0, 3)));
        4:    bus_write(0, 8'h08 | 8'($urandom_range(0, 7)));
        5:    bus_write(0, 8'h20 | 8'($urandom_range(0, 31)));
        6:    bus_write(0, ($urandom_range(0, 1) != 0) ? (8'h40 | 8'($urandom_range(0, 63)))
                                                       : (8'h10 | 8'($urandom_range(0, 15))));
        7:    bus_write(0, 8'h02 | 8'($urandom_range(0, 1)));
        8:    bus_write(0, ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
        9:    bus_read(1);
        10:   bus_read(0);
        default: begin
          bus_write(1, 8'($urandom));
          bus_read(0);
          bus_write(1'($urandom_range(0, 1)), 8'($urandom));
        end
      endcase
      wait_idle();
      check_state();
      if (i % 4 == 0) check_rd(5'($urandom_range(0, 31)));
    end
    check_all_buf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Cycle-accurate HD44780-style responder: the LCD end of the 8-bit EN/RW/RS/DATA bus that the LCD controller drives.
- Decodes instruction and data writes and holds a 2x16 character buffer with a readback port.
- Drives busy flag and address counter on status reads.
- Used as the on-board loopback target and as the bench model for frequency-meter display verification.

Parameters:
- BUSY_CYCLES, 2000, clk cycles busy after any executed write except clear/home (40 us at 50 MHz).
- CLEAR_CYCLES, 76500, clk cycles busy after clear display or return home (1.53 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- LCD_EN  in  1  bus enable strobe.
- LCD_RW  in  1  1 = read, 0 = write.
- LCD_RS  in  1  0 = instruction/status, 1 = data.
- LCD_DATA_IN  in  8  bus data from controller.
- lcd_data_out  out  8  read data driven back onto the bus.
- lcd_data_oe  out  1  high while read data is being driven.
- rd_addr  in  5  buffer readback index: [4] = line, [3:0] = column.
- rd_char  out  8  buffer byte at rd_addr, registered, 1-cycle latency.
- busy  out  1  busy flag.
- addr_counter  out  7  current DDRAM address counter (AC).
- display_on  out  1  D bit of display control.
- func_8bit_2line  out  2  {DL, N} from function set.
- violation  out  1  sticky; set when a write strobe arrives while busy.

Behaviour:
- Clock and reset: one clock domain. The bus is sampled directly, with no synchronisers. Registers en_q/rw_q/rs_q/data_q are loaded every cycle.
- Write strobe: en_q=1 & LCD_EN=0 & rw_q=0. Command byte = data_q and selector = rs_q, both taken from the last cycle EN was high.
- Read: while LCD_EN=1 & LCD_RW=1, lcd_data_oe=1 from the next cycle.
  - RS=0: lcd_data_out = {busy, AC}.
  - RS=1: lcd_data_out = buffer byte at AC; AC advances per I/D on the EN falling edge.
  - Outside reads, lcd_data_oe=0 and lcd_data_out=0.
- Instruction decode, highest set bit wins:
  - 1xxxxxxx: AC <= cmd[6:0].
  - 001DNFxx: DL,N latched.
  - 00001DCB: display_on <= D.
  - 000001IS: I/D latched; S is ignored.
  - 0000001x: return home, AC <= 0.
  - 00000001: clear display.
  - 01xxxxxx (CGRAM) and 0001xxxx (shift) are accepted, cause no state change, and start BUSY_CYCLES.
- Data write: if AC is in 0x00-0x0F, the byte goes to line 0, column AC[3:0]. If AC is in 0x40-0x4F, it goes to line 1. Other addresses write nothing. AC then advances.
- AC advance:
  - I/D=1: +1, with 0x27 -> 0x40 and 0x67 -> 0x00.
  - I/D=0: -1, with 0x40 -> 0x27 and 0x00 -> 0x67.
  - An AC set outside 0x00-0x27 or 0x40-0x67 is stored as given. The next increment from such a value goes to 0x00.
- FSM:
  - IDLE: busy=0. On a write strobe, go to EXEC, or go to FILL for clear.
  - FILL: writes 0x20 to all 32 locations, one per cycle (32 cycles). Then AC=0, I/D=1, load busy timer with CLEAR_CYCLES, go to EXEC.
  - EXEC: busy=1. Timer counts down to 0, then IDLE. Return home loads CLEAR_CYCLES; all other commands load BUSY_CYCLES.
- Busy and violations:
  - busy is 1 in FILL and EXEC.
  - A write strobe while busy=1 sets violation and is otherwise ignored.
  - A read while busy is legal.
  - violation clears only on rst.
- Simultaneous events: readback (rd_addr) is a second port and is never blocked, including during FILL. A read of a location in the same cycle it is written returns the old value.
- Reset values: lcd_data_out=0, lcd_data_oe=0, rd_char=0, AC=0, I/D=1, display_on=0, func_8bit_2line=2'b00, violation=0.
  - After reset the FSM enters FILL, so busy=1 for 32 cycles.
  - After those 32 cycles all locations read 0x20 and the FSM goes straight to IDLE without the CLEAR_CYCLES wait.
  - rst mid-FILL or mid-EXEC restarts this sequence.
- Width: busy timer is 17 bits. Timer loads truncate a parameter to 17 bits, which must fit.

Test Plan:
- Reset, wait 32 cycles -> busy=0; rd_addr 0x00 and 0x1F read 0x20.
- Init sequence 0x38, 0x08, 0x01, 0x06, 0x0C, each after busy drops:
  - func_8bit_2line=2'b11, display_on=1, AC=0.
  - busy stays high 32+76500 cycles after 0x01.
- Write instruction 0xCF, then data 0x7A -> rd_addr 0x1F = 0x7A, AC=0x50.
- Entry mode 0x04, set AC 0x00, data 0x31 -> AC=0x67. Second write 0x32 is dropped with AC=0x66.
- Status read (RS=0, RW=1) immediately after a write -> lcd_data_out[7]=1 and lcd_data_oe=1 while EN high. A second write during busy -> violation=1 and buffer unchanged.
- Set AC 0x27, write 0x41 -> AC=0x40. Assert rst mid-EXEC -> busy=1 for 32 cycles, buffer all 0x20, violation=0.
